vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 800x600 @ 72 Hz VGA raster timing from the 100 MHz system clock and the slow game-update clock. Drives the snake game block with pixel coordinates (CurrentX, CurrentY), blanking flags (HBlank, VBlank) and CLK_update, and drives the board's HSync/VSync pins. CLK_update rises only inside vertical blanking, so snake position updates never tear a visible frame.

## Interface

Parameters:
- H_VISIBLE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_VISIBLE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- UPDATE_FRAMES, 8, frames per CLK_update period (≥2)
- SYNC_POL, 1, sync active level (1 = active-high)

Ports:
- CLK_100MHz  in  1  system clock
- Reset  in  1  synchronous, active-high
- pixelEn  out  1  50 MHz pixel-enable strobe
- CurrentX  out  11  horizontal counter, 0..H_TOTAL-1
- CurrentY  out  11  vertical counter, 0..V_TOTAL-1
- HBlank  out  1  high when CurrentX ≥ H_VISIBLE
- VBlank  out  1  high when CurrentY ≥ V_VISIBLE
- HSync  out  1  horizontal sync pin
- VSync  out  1  vertical sync pin
- frameTick  out  1  one-clock pulse at frame start
- CLK_update  out  1  game-update clock

## Operation

- H_TOTAL = 1040 and V_TOTAL = 666 (sums of the respective parameters).
- pixelEn is a register that toggles every clock. Reset value is 0, so its first high is the first clock after Reset is released.
- Horizontal counter hcnt increments on clock edges where pixelEn = 1. It wraps from H_TOTAL-1 to 0.
- On the hcnt wrap, vcnt increments. vcnt wraps from V_TOTAL-1 to 0.
- CurrentX = hcnt and CurrentY = vcnt, with no added latency.
- HBlank and VBlank are combinational decodes of the counter registers.
- HSync is active (level SYNC_POL) for hcnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [856, 975]. It is inactive otherwise.
- VSync is active for vcnt in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] = [637, 642].
- Frame counter fcnt counts 0..UPDATE_FRAMES-1. It increments at each (H_TOTAL-1, V_TOTAL-1) → (0, 0) wrap and wraps to 0 after the last frame.
- frameTick is registered. It is high for exactly one clock: the first clock in which the counters read (0, 0) after a wrap. It does not assert on the (0, 0) state that immediately follows Reset.
- CLK_update is registered:
  - It rises on the first clock with (hcnt, vcnt) = (0, V_VISIBLE), only when fcnt = UPDATE_FRAMES-1.
  - It falls on the first clock with (hcnt, vcnt) = (0, 0).
  - It stays low in all other frames.
- Reset values: pixelEn 0, CurrentX 0, CurrentY 0, HBlank 0, VBlank 0, HSync and VSync inactive (~SYNC_POL), frameTick 0, CLK_update 0, fcnt 0.
- Reset mid-frame: all of the above return to reset values on the next edge. A CLK_update that is high drops to 0 immediately, with no glitch-extension.
- Counter widths: 11 bits each. Comparisons are unsigned, with no overflow beyond the TOTAL wrap.

## Timing

- One pixel = 2 clocks; one line = 2080 clocks; one frame = 1,385,280 clocks (≈72.19 Hz).
- CLK_update period = UPDATE_FRAMES × 1,385,280 = 11,082,240 clocks at default (≈9.02 Hz).
- CLK_update high time = (V_TOTAL − V_VISIBLE) lines = 66 × 2080 = 137,280 clocks, entirely inside VBlank.
- After Reset deasserts: pixelEn = 1 on clock 1, and CurrentX = 1 from clock 2.
- HBlank rises 1600 clocks after the line's X = 0 edge and lasts 480 clocks.
- The HSync active window is 240 clocks; the VSync active window is 12,480 clocks.
- All outputs change only on rising CLK_100MHz edges. Decodes are glitch-free relative to the counter registers.

## Test plan

- Hold Reset 5 clocks, release → all outputs at listed reset values during Reset. CurrentX = 1 on the 2nd clock after release. frameTick stays 0 at the initial (0, 0).
- Run one line → HBlank rises at CurrentX = 800. HSync is active exactly for CurrentX 856..975 (240 clocks). CurrentX wraps 1039 → 0 and CurrentY goes 0 → 1 on that edge.
- Run one full frame → VBlank high for CurrentY 600..665. VSync active for lines 637..642. frameTick pulses once, 1,385,280 clocks after the previous pulse.
- Run 17 frames with UPDATE_FRAMES = 8 → CLK_update rises at (0, 600) of frames 7 and 15 only. Each high lasts 137,280 clocks. Rising edges are 11,082,240 clocks apart.
- Assert Reset at (hcnt 400, vcnt 620) of frame 7 while CLK_update = 1 → next edge gives CLK_update = 0, counters = 0, fcnt = 0. The next CLK_update rise occurs 8 frames later.
- Set SYNC_POL = 0 → HSync and VSync idle high and pulse low in the same windows. All other timing is unchanged.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 800x600@72Hz VGA raster timing: pixel strobe, X/Y counters, blanking/sync decodes,
// frame tick and a game-update clock that only rises inside vertical blanking.
module vga_timing_gen #(
   parameter int H_VISIBLE     = 800,
   parameter int H_FP          = 56,
   parameter int H_SYNC        = 120,
   parameter int H_BP          = 64,
   parameter int V_VISIBLE     = 600,
   parameter int V_FP          = 37,
   parameter int V_SYNC        = 6,
   parameter int V_BP          = 23,
   parameter int UPDATE_FRAMES = 8,
   parameter bit SYNC_POL      = 1'b1
) (
   input  logic        CLK_100MHz,
   input  logic        Reset,
   output logic        pixelEn,
   output logic [10:0] CurrentX,
   output logic [10:0] CurrentY,
   output logic        HBlank,
   output logic        VBlank,
   output logic        HSync,
   output logic        VSync,
   output logic        frameTick,
   output logic        CLK_update
);
   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int FW      = (UPDATE_FRAMES > 1) ? $clog2(UPDATE_FRAMES) : 1;

   localparam logic [10:0]   H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0]   V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0]   H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0]   V_VIS    = 11'(V_VISIBLE);
   localparam logic [10:0]   V_VIS_M1 = 11'(V_VISIBLE - 1);
   localparam logic [10:0]   HS_FIRST = 11'(H_VISIBLE + H_FP);
   localparam logic [10:0]   HS_LAST  = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [10:0]   VS_FIRST = 11'(V_VISIBLE + V_FP);
   localparam logic [10:0]   VS_LAST  = 11'(V_VISIBLE + V_FP + V_SYNC - 1);
   localparam logic [FW-1:0] F_LAST   = FW'(UPDATE_FRAMES - 1);

   logic [10:0]   hCnt;
   logic [10:0]   vCnt;
   logic [FW-1:0] fCnt;
   logic          lineEnd;
   logic          frameEnd;
   logic          updateStart;

   // Wrap strobes: true on the edge that moves the counters past a line/frame boundary.
   always_comb begin
      lineEnd     = pixelEn && (hCnt == H_LAST);
      frameEnd    = lineEnd && (vCnt == V_LAST);
      updateStart = lineEnd && (vCnt == V_VIS_M1) && (fCnt == F_LAST);
   end

   // Pixel strobe and raster counters.
   always_ff @(posedge CLK_100MHz) begin
      if (Reset) begin
         pixelEn <= 1'b0;
         hCnt    <= 11'd0;
         vCnt    <= 11'd0;
         fCnt    <= '0;
      end else begin
         pixelEn <= ~pixelEn;
         if (lineEnd) begin
            hCnt <= 11'd0;
            vCnt <= (vCnt == V_LAST) ? 11'd0 : (vCnt + 11'd1);
         end else if (pixelEn) begin
            hCnt <= hCnt + 11'd1;
         end else begin
            hCnt <= hCnt;
         end
         if (frameEnd) begin
            fCnt <= (fCnt == F_LAST) ? '0 : (fCnt + FW'(1));
         end else begin
            fCnt <= fCnt;
         end
      end
   end

   // frameTick marks the first (0,0) clock after a wrap; CLK_update spans the VBlank of the last frame.
   always_ff @(posedge CLK_100MHz) begin
      if (Reset) begin
         frameTick  <= 1'b0;
         CLK_update <= 1'b0;
      end else begin
         frameTick <= frameEnd;
         if (frameEnd) begin
            CLK_update <= 1'b0;
         end else if (updateStart) begin
            CLK_update <= 1'b1;
         end else begin
            CLK_update <= CLK_update;
         end
      end
   end

   // Position, blanking and sync decodes taken straight from the counter registers.
   always_comb begin
      CurrentX = hCnt;
      CurrentY = vCnt;
      HBlank   = (hCnt >= H_VIS);
      VBlank   = (vCnt >= V_VIS);
      HSync    = ((hCnt >= HS_FIRST) && (hCnt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
      VSync    = ((vCnt >= VS_FIRST) && (vCnt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (15x12 totals, 8 frames per update),
// one instance per sync polarity, checked every clock against an arithmetic model.
module tb_vga_timing_gen;
   localparam int HVIS = 8, HFP = 2, HSY = 3, HBP = 2;
   localparam int VVIS = 6, VFP = 2, VSY = 2, VBP = 2;
   localparam int UF   = 8;
   localparam int HT   = HVIS + HFP + HSY + HBP;   // 15
   localparam int VT   = VVIS + VFP + VSY + VBP;   // 12
   localparam int FRAME_CLKS = 2 * HT * VT;        // 360

   logic CLK_100MHz = 1'b0;
   logic Reset      = 1'b1;

   logic        pixelEn, HBlank, VBlank, HSync, VSync, frameTick, CLK_update;
   logic [10:0] CurrentX, CurrentY;
   logic        pixelEnB, HBlankB, VBlankB, HSyncB, VSyncB, frameTickB, CLK_updateB;
   logic [10:0] CurrentXB, CurrentYB;

   vga_timing_gen #(
      .H_VISIBLE(HVIS), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_VISIBLE(VVIS), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .UPDATE_FRAMES(UF), .SYNC_POL(1'b1)
   ) dutPos (
      .CLK_100MHz(CLK_100MHz), .Reset(Reset), .pixelEn(pixelEn),
      .CurrentX(CurrentX), .CurrentY(CurrentY), .HBlank(HBlank), .VBlank(VBlank),
      .HSync(HSync), .VSync(VSync), .frameTick(frameTick), .CLK_update(CLK_update)
   );

   vga_timing_gen #(
      .H_VISIBLE(HVIS), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_VISIBLE(VVIS), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .UPDATE_FRAMES(UF), .SYNC_POL(1'b0)
   ) dutNeg (
      .CLK_100MHz(CLK_100MHz), .Reset(Reset), .pixelEn(pixelEnB),
      .CurrentX(CurrentXB), .CurrentY(CurrentYB), .HBlank(HBlankB), .VBlank(VBlankB),
      .HSync(HSyncB), .VSync(VSyncB), .frameTick(frameTickB), .CLK_update(CLK_updateB)
   );

   always #5 CLK_100MHz = ~CLK_100MHz;

   int vectors     = 0;
   int miscompares = 0;

   // t = edges since the last reset edge; releases = number of reset releases seen.
   int cyc      = 0;
   int t        = 0;
   int releases = 0;
   logic inReset = 1'b1;

   always @(posedge CLK_100MHz) begin
      cyc <= cyc + 1;
      if (Reset) begin
         t       <= 0;
         inReset <= 1'b1;
      end else begin
         t <= t + 1;
         if (inReset) releases <= releases + 1;
         inReset <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0d actual=%0d expected=%0d", name, t, act, exp);
      end
   endtask

   int pix, xM, yM, fM;
   logic hsM, vsM, updM, tickM;
   logic prevUpd  = 1'b0;
   logic prevTick = 1'b0;
   int prevRise   = -1;
   int prevTickC  = -1;
   int riseCount  = 0;

   always @(negedge CLK_100MHz) begin
      if (cyc > 0) begin
         pix   = t / 2;
         xM    = pix % HT;
         yM    = (pix / HT) % VT;
         fM    = pix / (HT * VT);
         hsM   = (xM >= HVIS + HFP) && (xM < HVIS + HFP + HSY);
         vsM   = (yM >= VVIS + VFP) && (yM < VVIS + VFP + VSY);
         updM  = ((fM % UF) == UF - 1) && (yM >= VVIS);
         tickM = (t > 0) && ((t % FRAME_CLKS) == 0);

         chk("pixelEn", pixelEn, t % 2);
         chk("CurrentX", CurrentX, xM);
         chk("CurrentY", CurrentY, yM);
         chk("HBlank", HBlank, xM >= HVIS);
         chk("VBlank", VBlank, yM >= VVIS);
         chk("HSync", HSync, hsM);
         chk("VSync", VSync, vsM);
         chk("frameTick", frameTick, tickM);
         chk("CLK_update", CLK_update, updM);
         chk("neg_HSync", HSyncB, !hsM);
         chk("neg_VSync", VSyncB, !vsM);
         chk("neg_CurrentX", CurrentXB, xM);
         chk("neg_CurrentY", CurrentYB, yM);
         chk("neg_CLK_update", CLK_updateB, updM);
         chk("neg_frameTick", frameTickB, tickM);

         if (t == 0) begin
            prevRise  = -1;
            prevTickC = -1;
            riseCount = 0;
         end

         // Edge-to-edge intervals measured in absolute clocks.
         if (CLK_update && !prevUpd) begin
            riseCount++;
            if (prevRise < 0) chk("first_update_rise_t", t, 2700);
            else              chk("update_period", cyc - prevRise, 8 * FRAME_CLKS);
            prevRise = cyc;
         end
         if (!CLK_update && prevUpd && t != 0) chk("update_high_len", cyc - prevRise, 180);
         if (frameTick && !prevTick) begin
            if (prevTickC >= 0) chk("tick_period", cyc - prevTickC, FRAME_CLKS);
            prevTickC = cyc;
         end
         prevUpd  = CLK_update;
         prevTick = frameTick;

         // Hand-computed anchors for the shrunken raster.
         if (releases == 0) begin
            chk("rst_pixelEn", pixelEn, 0);
            chk("rst_X", CurrentX, 0);
            chk("rst_Y", CurrentY, 0);
            chk("rst_HBlank", HBlank, 0);
            chk("rst_VBlank", VBlank, 0);
            chk("rst_HSync", HSync, 0);
            chk("rst_VSyncNeg", VSyncB, 1);
            chk("rst_frameTick", frameTick, 0);
            chk("rst_update", CLK_update, 0);
         end else if (releases == 1) begin
            case (t)
               0:    begin chk("midrst_update", CLK_update, 0); chk("midrst_X", CurrentX, 0); chk("midrst_Y", CurrentY, 0); end
               1:    begin chk("pixelEn_t1", pixelEn, 1); chk("X_t1", CurrentX, 0); chk("tick_t1", frameTick, 0); end
               2:    chk("X_t2", CurrentX, 1);
               15:   chk("HBlank_t15", HBlank, 0);
               16:   begin chk("HBlank_t16", HBlank, 1); chk("X_t16", CurrentX, 8); end
               19:   chk("HSync_t19", HSync, 0);
               20:   begin chk("HSync_t20", HSync, 1); chk("HSyncNeg_t20", HSyncB, 0); end
               25:   chk("HSync_t25", HSync, 1);
               26:   chk("HSync_t26", HSync, 0);
               29:   begin chk("X_t29", CurrentX, 14); chk("Y_t29", CurrentY, 0); end
               30:   begin chk("X_t30", CurrentX, 0); chk("Y_t30", CurrentY, 1); end
               179:  chk("VBlank_t179", VBlank, 0);
               180:  chk("VBlank_t180", VBlank, 1);
               240:  chk("VSync_t240", VSync, 1);
               300:  chk("VSync_t300", VSync, 0);
               360:  begin chk("tick_t360", frameTick, 1); chk("X_t360", CurrentX, 0); end
               361:  chk("tick_t361", frameTick, 0);
               2699: chk("update_t2699", CLK_update, 0);
               2700: chk("update_t2700", CLK_update, 1);
               2879: chk("update_t2879", CLK_update, 1);
               2880: chk("update_t2880", CLK_update, 0);
               6120: chk("rises_in_17_frames", riseCount, 2);
               8528: begin chk("pre_rst_update", CLK_update, 1); chk("pre_rst_X", CurrentX, 4); chk("pre_rst_Y", CurrentY, 8); end
               default: ;
            endcase
         end else begin
            case (t)
               2699:    chk("post_rst_update_t2699", CLK_update, 0);
               2700:    chk("post_rst_update_t2700", CLK_update, 1);
               default: ;
            endcase
         end
      end
   end

   initial begin
      repeat (5) @(negedge CLK_100MHz);
      Reset = 1'b0;
      repeat (8528) @(negedge CLK_100MHz);
      Reset = 1'b1;
      @(negedge CLK_100MHz);
      Reset = 1'b0;
      repeat (2900) @(negedge CLK_100MHz);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
